// File: rtl/urv_imem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | urv_imem_arbiter_if : fetch, host and RAM signal bundle for the arbiter     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface urv_imem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] im_addr_i;
  logic [31:0]       im_data_o;
  logic              im_valid_o;
  logic              host_req_i;
  logic              host_we_i;
  logic [3:0]        host_sel_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [31:0]       host_wdata_i;
  logic              host_ack_o;
  logic [31:0]       host_rdata_o;
  logic [ADDR_W-3:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_bwe_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  im_addr_i, host_req_i, host_we_i, host_sel_i, host_addr_i, host_wdata_i, mem_rdata_i,
    output im_data_o, im_valid_o, host_ack_o, host_rdata_o, mem_addr_o, mem_we_o, mem_bwe_o,
           mem_wdata_o
  );

  modport master (
    output im_addr_i, host_req_i, host_we_i, host_sel_i, host_addr_i, host_wdata_i, mem_rdata_i,
    input  im_data_o, im_valid_o, host_ack_o, host_rdata_o, mem_addr_o, mem_we_o, mem_bwe_o,
           mem_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/urv_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | urv_imem_arbiter : shares one instruction RAM between fetch and a host port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module urv_imem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int HOST_MAX_WAIT = 8
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  urv_imem_arbiter_if.slave bus
);

  localparam int CNT_W = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(HOST_MAX_WAIT);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ACK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             grant_host;
  logic             last_fetch;
  logic             host_ack;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      last_fetch <= 1'b0;
      host_ack   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      last_fetch <= !grant_host;
      host_ack   <= grant_host;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant_host   = 1'b0;
    case (state)
      ST_RUN: begin
        grant_host = bus.host_req_i && ((HOST_MAX_WAIT == 0) || (wait_cnt == WAIT_LIMIT));
        if (grant_host) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
    // Counter saturates so a long-pending host keeps its forced-grant eligibility.
    if (grant_host || !bus.host_req_i) begin
      wait_cnt_nxt = '0;
    end else if ((state == ST_RUN) && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  assign bus.mem_addr_o   = grant_host ? bus.host_addr_i[ADDR_W-1:2] : bus.im_addr_i[ADDR_W-1:2];
  assign bus.mem_we_o     = grant_host && bus.host_we_i;
  assign bus.mem_bwe_o    = bus.mem_we_o ? bus.host_sel_i : 4'b0000;
  assign bus.mem_wdata_o  = bus.host_wdata_i;
  assign bus.im_data_o    = bus.mem_rdata_i;
  assign bus.host_rdata_o = bus.mem_rdata_i;
  assign bus.im_valid_o   = last_fetch;
  assign bus.host_ack_o   = host_ack;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_addr_i[1:0], bus.host_addr_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_urv_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_urv_imem_arbiter : two arbiters (HOST_MAX_WAIT 8 and 0) vs a cycle model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_urv_imem_arbiter;
  localparam int ADDR_W = 16;
  localparam int AW     = ADDR_W - 2;
  localparam int NW     = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  urv_imem_arbiter_if #(.ADDR_W(ADDR_W)) bus0 ();
  urv_imem_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

  urv_imem_arbiter #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(8)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0.slave));
  urv_imem_arbiter #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1.slave));

  logic [ADDR_W-1:0] im_addr[2];
  logic              host_req[2];
  logic              host_we[2];
  logic [3:0]        host_sel[2];
  logic [ADDR_W-1:0] host_addr[2];
  logic [31:0]       host_wdata[2];
  logic [31:0]       ram_rd[2];

  logic [AW-1:0] o_addr[2];
  logic          o_we[2], o_ack[2], o_valid[2];
  logic [3:0]    o_bwe[2];
  logic [31:0]   o_wdata[2], o_imdata[2], o_hrdata[2];

  assign bus0.im_addr_i = im_addr[0];   assign bus1.im_addr_i = im_addr[1];
  assign bus0.host_req_i = host_req[0]; assign bus1.host_req_i = host_req[1];
  assign bus0.host_we_i = host_we[0];   assign bus1.host_we_i = host_we[1];
  assign bus0.host_sel_i = host_sel[0]; assign bus1.host_sel_i = host_sel[1];
  assign bus0.host_addr_i = host_addr[0]; assign bus1.host_addr_i = host_addr[1];
  assign bus0.host_wdata_i = host_wdata[0]; assign bus1.host_wdata_i = host_wdata[1];
  assign bus0.mem_rdata_i = ram_rd[0];  assign bus1.mem_rdata_i = ram_rd[1];

  assign o_addr[0] = bus0.mem_addr_o;     assign o_addr[1] = bus1.mem_addr_o;
  assign o_we[0] = bus0.mem_we_o;         assign o_we[1] = bus1.mem_we_o;
  assign o_bwe[0] = bus0.mem_bwe_o;       assign o_bwe[1] = bus1.mem_bwe_o;
  assign o_wdata[0] = bus0.mem_wdata_o;   assign o_wdata[1] = bus1.mem_wdata_o;
  assign o_ack[0] = bus0.host_ack_o;      assign o_ack[1] = bus1.host_ack_o;
  assign o_valid[0] = bus0.im_valid_o;    assign o_valid[1] = bus1.im_valid_o;
  assign o_imdata[0] = bus0.im_data_o;    assign o_imdata[1] = bus1.im_data_o;
  assign o_hrdata[0] = bus0.host_rdata_o; assign o_hrdata[1] = bus1.host_rdata_o;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return ({18'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Single-port RAM with registered, read-first output; unwritten words hold init_word().
  bit [31:0] ram_mem[2][NW];
  bit        ram_wr[2][NW];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ram_rd[k] <= ram_wr[k][o_addr[k]] ? ram_mem[k][o_addr[k]] : init_word(o_addr[k]);
      if (o_we[k]) begin
        ram_wr[k][o_addr[k]]  <= 1'b1;
        ram_mem[k][o_addr[k]] <= merge(ram_wr[k][o_addr[k]] ? ram_mem[k][o_addr[k]]
                                       : init_word(o_addr[k]), o_wdata[k], o_bwe[k]);
      end
    end
  end

  // Reference model: a host request becomes eligible once it has waited MAXW
  // eligible cycles; the cycle after any grant is never eligible.
  bit [31:0] gmem[2][NW];
  int        m_waited[2];
  bit        m_prev_grant[2], m_ack[2], m_valid[2], e_grant[2];
  logic [31:0] m_rd[2];

  function automatic int maxw(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_waited[k] = 0; m_prev_grant[k] = 0; m_ack[k] = 0; m_valid[k] = 0; e_grant[k] = 0;
    end
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < 2; k++)
      e_grant[k] = host_req[k] && !m_prev_grant[k] && (m_waited[k] >= maxw(k));
  endfunction

  function automatic void model_commit();
    logic [AW-1:0] wa;
    model_eval();
    for (int k = 0; k < 2; k++) begin
      wa = e_grant[k] ? host_addr[k][ADDR_W-1:2] : im_addr[k][ADDR_W-1:2];
      m_ack[k]   = e_grant[k];
      m_valid[k] = !e_grant[k];
      m_rd[k]    = gmem[k][wa];
      if (e_grant[k] && host_we[k]) gmem[k][wa] = merge(gmem[k][wa], host_wdata[k], host_sel[k]);
      if (!host_req[k] || e_grant[k]) m_waited[k] = 0;
      else if (!m_prev_grant[k])      m_waited[k] = m_waited[k] + 1;
      m_prev_grant[k] = e_grant[k];
    end
  endfunction

  task automatic clk_cycle();
    @(posedge clk);
    if (rst_n) model_commit(); else model_reset();
    @(negedge clk);
  endtask

  int vectors = 0;
  int miscompares = 0;
  bit pending[2];

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      im_addr[k] = '0; host_req[k] = 0; host_we[k] = 0; host_sel[k] = '0;
      host_addr[k] = '0; host_wdata[k] = '0;
    end
    model_reset();
    repeat (3) clk_cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_ack[k] !== 1'b0 || o_valid[k] !== 1'b0 || o_we[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: ack=%b valid=%b we=%b, want all 0", k, o_ack[k], o_valid[k], o_we[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) im_addr[k] = ADDR_W'(i * 4);
      model_eval();
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_addr[k] !== AW'(i) || o_valid[k] !== (i != 0)) begin
          miscompares++;
          $display("FAIL fetch_stream[%0d] i=%0d: addr=%h valid=%b, want %h %b", k, i,
                   o_addr[k], o_valid[k], AW'(i), (i != 0));
        end
        if (i > 0) begin
          vectors++;
          if (o_imdata[k] !== gmem[k][i-1]) begin
            miscompares++;
            $display("FAIL fetch_data[%0d] i=%0d: got %h want %h", k, i, o_imdata[k], gmem[k][i-1]);
          end
        end
      end
      clk_cycle();
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < 2; k++) pending[k] = 0;
    for (int c = 0; c < n + 24; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_ack[k]) pending[k] = 0;
        if (!pending[k] && c < n && $urandom_range(0, 2) == 0) begin
          pending[k]    = 1;
          host_we[k]    = 1'($urandom_range(0, 1));
          host_sel[k]   = 4'($urandom);
          host_addr[k]  = ADDR_W'({$urandom_range(0, 15), 2'($urandom)});
          host_wdata[k] = $urandom;
        end
        host_req[k] = pending[k];
        im_addr[k]  = ADDR_W'({$urandom_range(0, 15), 2'($urandom)});
      end
      model_eval();
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [AW-1:0] xa;
        logic          xwe;
        xa  = e_grant[k] ? host_addr[k][ADDR_W-1:2] : im_addr[k][ADDR_W-1:2];
        xwe = e_grant[k] && host_we[k];
        vectors++;
        if (o_addr[k] !== xa || o_we[k] !== xwe || o_bwe[k] !== (xwe ? host_sel[k] : 4'b0)
            || o_wdata[k] !== host_wdata[k]) begin
          miscompares++;
          $display("FAIL rand_bus[%0d] c=%0d: addr=%h we=%b bwe=%b wd=%h, want %h %b %b %h", k, c,
                   o_addr[k], o_we[k], o_bwe[k], o_wdata[k], xa, xwe,
                   (xwe ? host_sel[k] : 4'b0), host_wdata[k]);
        end
        vectors++;
        if (o_ack[k] !== m_ack[k] || o_valid[k] !== m_valid[k]) begin
          miscompares++;
          $display("FAIL rand_hs[%0d] c=%0d: ack=%b valid=%b, want %b %b", k, c,
                   o_ack[k], o_valid[k], m_ack[k], m_valid[k]);
        end
        if (m_valid[k] || m_ack[k]) begin
          vectors++;
          if (o_imdata[k] !== m_rd[k] || o_hrdata[k] !== m_rd[k]) begin
            miscompares++;
            $display("FAIL rand_data[%0d] c=%0d: im=%h host=%h, want %h", k, c,
                     o_imdata[k], o_hrdata[k], m_rd[k]);
          end
        end
      end
      clk_cycle();
    end
  endtask

  task automatic test_host_wait();
    int waited = 0;
    bit got = 0;
    host_req[0] = 1; host_we[0] = 0; host_addr[0] = 16'h0040; im_addr[0] = 16'h0200;
    for (int c = 0; c < 20 && !got; c++) begin
      model_eval();
      #1;
      if (o_addr[0] === AW'(16'h10)) got = 1;
      else begin waited++; clk_cycle(); end
    end
    vectors++;
    if (!got || waited != 8 || o_we[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL host_wait: got=%b waited=%0d we=%b, want 1 8 0", got, waited, o_we[0]);
    end
    clk_cycle();
    host_req[0] = 0;
    model_eval();
    #1;
    vectors++;
    if (o_ack[0] !== 1'b1 || o_valid[0] !== 1'b0 || o_hrdata[0] !== gmem[0][16'h10]) begin
      miscompares++;
      $display("FAIL host_ack: ack=%b valid=%b rdata=%h, want 1 0 %h", o_ack[0], o_valid[0],
               o_hrdata[0], gmem[0][16'h10]);
    end
    clk_cycle();
    #1;
    vectors++;
    if (o_ack[0] !== 1'b0 || o_valid[0] !== 1'b1 || o_imdata[0] !== gmem[0][16'h80]) begin
      miscompares++;
      $display("FAIL host_resume: ack=%b valid=%b im=%h, want 0 1 %h", o_ack[0], o_valid[0],
               o_imdata[0], gmem[0][16'h80]);
    end
  endtask

  task automatic test_host_write();
    logic [31:0] old_w, new_w;
    old_w = gmem[1][16'h40];
    new_w = {old_w[31:16], 16'hBEEF};
    host_req[1] = 1; host_we[1] = 1; host_addr[1] = 16'h0100;
    host_wdata[1] = 32'hDEAD_BEEF; host_sel[1] = 4'b0011; im_addr[1] = 16'h0020;
    model_eval();
    #1;
    vectors++;
    if (o_we[1] !== 1'b1 || o_bwe[1] !== 4'b0011 || o_addr[1] !== AW'(16'h40)
        || o_wdata[1] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL host_write: we=%b bwe=%b addr=%h wd=%h, want 1 0011 040 deadbeef",
               o_we[1], o_bwe[1], o_addr[1], o_wdata[1]);
    end
    clk_cycle();
    host_req[1] = 0; host_we[1] = 0; im_addr[1] = 16'h0100;
    model_eval();
    #1;
    vectors++;
    if (o_ack[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL write_ack: ack=%b want 1", o_ack[1]);
    end
    clk_cycle();
    #1;
    vectors++;
    if (o_valid[1] !== 1'b1 || o_imdata[1] !== new_w) begin
      miscompares++;
      $display("FAIL write_fetch: valid=%b im=%h, want 1 %h", o_valid[1], o_imdata[1], new_w);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    host_req[1] = 1; host_we[1] = 0; host_addr[1] = ADDR_W'({$urandom_range(32, 63), 2'b00});
    im_addr[1] = 16'h0008;
    for (int c = 0; c < 10; c++) begin
      model_eval();
      #1;
      if (o_ack[1] === 1'b1) acks++;
      vectors++;
      if (o_ack[1] !== c[0] || o_valid[1] !== !c[0]
          || o_addr[1] !== (c[0] ? AW'(2) : host_addr[1][ADDR_W-1:2])) begin
        miscompares++;
        $display("FAIL back_to_back c=%0d: ack=%b valid=%b addr=%h", c, o_ack[1], o_valid[1], o_addr[1]);
      end
      clk_cycle();
    end
    host_req[1] = 0;
    vectors++;
    if (acks != 5) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d acks want 5", acks);
    end
    clk_cycle();
  endtask

  task automatic test_reset_mid_grant();
    int waited = 0;
    int acks = 0;
    bit got = 0;
    host_req[0] = 1; host_we[0] = 0; host_addr[0] = 16'h0080; im_addr[0] = 16'h0200;
    for (int c = 0; c < 20 && !got; c++) begin
      model_eval();
      #1;
      if (o_addr[0] === AW'(16'h20)) got = 1;
      else clk_cycle();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (!got || o_ack[0] !== 1'b0 || o_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_grant: got=%b ack=%b valid=%b, want 1 0 0", got, o_ack[0], o_valid[0]);
    end
    repeat (2) clk_cycle();
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      model_eval();
      #1;
      if (o_addr[0] === AW'(16'h20)) got = 1;
      else begin waited++; clk_cycle(); end
    end
    vectors++;
    if (!got || waited != 8) begin
      miscompares++;
      $display("FAIL rst_regrant: got=%b waited=%0d, want 1 8", got, waited);
    end
    clk_cycle();
    host_req[0] = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (o_ack[0] === 1'b1) acks++;
      clk_cycle();
    end
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL rst_ack_count: got %0d acks want 1", acks);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < NW; a++) gmem[k][a] = init_word(AW'(a));
    @(negedge clk);
    test_reset();
    test_fetch_stream();
    test_random(300);
    test_host_wait();
    test_host_write();
    test_back_to_back();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
